load_use_scoreboard: RTL

- Stall-side companion to the pipeline forwarding unit. Forwarding consumes the MEM/WB write-select info; this block produces the decision to hold IF/ID and inject an ID/EX bubble.
- Tracks, per architectural register, how many cycles remain before an issued load's result becomes forwardable.
- Stalls decode while a consumed source is still unavailable.
- Sits beside the ID stage. It is driven by decode fields and the ID→EX issue event, and by the pipeline freeze (dcache wait).

---
 rtl/load_use_scoreboard.sv | 69 ++++++
 1 files changed

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: one countdown per architectural register tracks
// how long an issued load's result is unforwardable, and stalls decode on use.
module load_use_scoreboard #(
    parameter int NREGS      = 32,
    parameter int REGW       = 5,
    parameter int LOAD_DELAY = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic            id_wen,
    input  logic [REGW-1:0] id_wsel,
    input  logic            id_is_load,
    input  logic            freeze,
    output logic            stall,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_nop,
    output logic            load_pending
);

    localparam int CW = $clog2(LOAD_DELAY + 1);

    logic [NREGS-1:0][CW-1:0] cnt;
    logic [NREGS-1:0][CW-1:0] cnt_nxt;
    logic                     rs_busy;
    logic                     rt_busy;
    logic                     issue;

    // Hazard is judged against the counters as they stand before this edge,
    // so a load that reads its own destination never stalls on itself.
    assign rs_busy  = id_uses_rs && (cnt[id_rs] != '0);
    assign rt_busy  = id_uses_rt && (cnt[id_rt] != '0);
    assign stall    = id_valid && (rs_busy || rt_busy);
    assign pc_en    = !stall && !freeze;
    assign ifid_en  = !stall && !freeze;
    assign idex_nop = stall && !freeze;
    assign issue    = id_valid && !stall && !freeze;

    always_comb begin
        cnt_nxt    = cnt;
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (freeze) begin
                cnt_nxt[r] = cnt[r];
            end else if (issue && id_wen && (id_wsel == REGW'(r))) begin
                // A younger non-load write supersedes the pending load result.
                cnt_nxt[r] = id_is_load ? CW'(LOAD_DELAY) : '0;
            end else if (cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt          <= '0;
            load_pending <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            load_pending <= |cnt_nxt;
        end
    end

endmodule
